// File: rtl/dds_pkg.sv
// Shared state encoding, channel select and default sizing for the DDS
// configuration sequencer and its serial shifter.
package dds_pkg;

  localparam int DEF_ACC_LENGTH   = 48;
  localparam int DEF_PHASE_LENGTH = 16;
  localparam int DEF_CLK_DIV      = 4;
  localparam int DIV_W            = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    GAP      = 2'd3
  } dds_state_e;

  typedef enum logic {
    SEL_FREQ  = 1'b0,
    SEL_PHASE = 1'b1
  } dds_sel_e;

  function automatic int max_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dds_spi_shifter.sv
// Serial loader for the DDS: shifts a left-aligned word MSB first with a
// CLK_DIV spi_clk divider, then holds a chip-select-low gap.
//   state    | meaning
//   IDLE     | waiting for load
//   SHIFT_LO | spi_clk low, current bit presented on spi_data
//   SHIFT_HI | spi_clk high, DDS samples the bit
//   GAP      | both chip selects low before returning to IDLE
module dds_spi_shifter
  import dds_pkg::*;
#(
  parameter int  WORD_W  = DEF_ACC_LENGTH,
  parameter int  CLK_DIV = DEF_CLK_DIV,
  localparam int CNT_W   = $clog2(WORD_W + 1)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              load,
  input  dds_sel_e          load_sel,
  input  logic [WORD_W-1:0] load_word,
  input  logic [CNT_W-1:0]  load_width,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_data,
  output logic              freq_cs,
  output logic              phase_cs
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  dds_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  bits_q, bits_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              data_q, data_d;
  dds_sel_e          sel_q, sel_d;
  logic              spi_clk_q, spi_clk_d;
  logic              freq_cs_q, freq_cs_d;
  logic              phase_cs_q, phase_cs_d;
  logic              busy_q, busy_d;
  logic              cs_on;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT_LO;
          div_d   = DIV_LAST;
          bits_d  = load_width - 1'b1;
          data_d  = load_word[WORD_W-1];
          shreg_d = load_word << 1;
          sel_d   = load_sel;
        end
      end
      SHIFT_LO: begin
        if (div_q == '0) begin
          state_d = SHIFT_HI;
          div_d   = DIV_LAST;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_q == '0) begin
          div_d = DIV_LAST;
          if (bits_q == '0) begin
            state_d = GAP;
          end else begin
            state_d = SHIFT_LO;
            data_d  = shreg_q[WORD_W-1];
            shreg_d = shreg_q << 1;
            bits_d  = bits_q - 1'b1;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      GAP: begin
        if (div_q == '0) state_d = IDLE;
        else             div_d   = div_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the pins never glitch.
    cs_on      = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    spi_clk_d  = (state_d == SHIFT_HI);
    freq_cs_d  = cs_on && (sel_d == SEL_FREQ);
    phase_cs_d = cs_on && (sel_d == SEL_PHASE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bits_q     <= '0;
      shreg_q    <= '0;
      data_q     <= 1'b0;
      sel_q      <= SEL_FREQ;
      spi_clk_q  <= 1'b0;
      freq_cs_q  <= 1'b0;
      phase_cs_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      spi_clk_q  <= spi_clk_d;
      freq_cs_q  <= freq_cs_d;
      phase_cs_q <= phase_cs_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign spi_clk  = spi_clk_q;
  assign spi_data = data_q;
  assign freq_cs  = freq_cs_q;
  assign phase_cs = phase_cs_q;

endmodule

// File: rtl/dds_cfg_sequencer.sv
// DDS configuration sequencer: arbitrates freq/phase load requests onto one
// serial port. Optional frequency sweep engine enabled by DDS_CFG_SWEEP_EN.
module dds_cfg_sequencer
  import dds_pkg::*;
#(
  parameter int ACC_LENGTH   = DEF_ACC_LENGTH,
  parameter int PHASE_LENGTH = DEF_PHASE_LENGTH,
  parameter int CLK_DIV      = DEF_CLK_DIV
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    freq_valid,
  output logic                    freq_ready,
  input  logic [ACC_LENGTH-1:0]   freq_word,
  input  logic                    phase_valid,
  output logic                    phase_ready,
  input  logic [PHASE_LENGTH-1:0] phase_word,
`ifdef DDS_CFG_SWEEP_EN
  input  logic                    sweep_en,
  input  logic [ACC_LENGTH-1:0]   sweep_step,
  input  logic [15:0]             sweep_interval,
`endif
  output logic                    spi_clk,
  output logic                    spi_data,
  output logic                    freq_cs,
  output logic                    phaseshift_cs,
  output logic                    busy
);

  localparam int WORD_W = max_len(ACC_LENGTH, PHASE_LENGTH);
  localparam int CNT_W  = $clog2(WORD_W + 1);

  logic              rdy_q, rdy_d;
  dds_sel_e          rr_q, rr_d;
  logic              can_accept, freq_gnt, phase_gnt, sweep_gnt;
  logic              load;
  dds_sel_e          load_sel;
  logic [WORD_W-1:0] load_word, freq_aligned, phase_aligned;
  logic [CNT_W-1:0]  load_width;

  // rdy_q keeps ready low for the cycle in which reset is still registered.
  assign can_accept  = rdy_q & ~busy;
  assign freq_ready  = can_accept & (~phase_valid | (rr_q == SEL_FREQ));
  assign phase_ready = can_accept & (~freq_valid | (rr_q == SEL_PHASE));
  assign freq_gnt    = freq_valid & freq_ready;
  assign phase_gnt   = phase_valid & phase_ready;

  assign freq_aligned  = WORD_W'(freq_word) << (WORD_W - ACC_LENGTH);
  assign phase_aligned = WORD_W'(phase_word) << (WORD_W - PHASE_LENGTH);

`ifdef DDS_CFG_SWEEP_EN
  logic [ACC_LENGTH-1:0] cur_freq_q, cur_freq_d, sweep_freq;
  logic [15:0]           tmr_q, tmr_d;
  logic                  sweep_pend_q, sweep_pend_d, sweep_tick;

  assign sweep_freq = cur_freq_q + sweep_step;
  assign sweep_gnt  = can_accept & sweep_pend_q & ~freq_valid & ~phase_valid;

  always_comb begin
    tmr_d      = tmr_q;
    sweep_tick = 1'b0;
    if (!sweep_en || (sweep_interval == '0)) begin
      tmr_d = sweep_interval - 1'b1;
    end else if (tmr_q == '0) begin
      tmr_d      = sweep_interval - 1'b1;
      sweep_tick = 1'b1;
    end else begin
      tmr_d = tmr_q - 1'b1;
    end
    // A single pending flag means a tick during busy is held, never doubled.
    sweep_pend_d = sweep_en & ((sweep_pend_q & ~sweep_gnt) | sweep_tick);
    cur_freq_d   = cur_freq_q;
    if (freq_gnt)       cur_freq_d = freq_word;
    else if (sweep_gnt) cur_freq_d = sweep_freq;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cur_freq_q   <= '0;
      tmr_q        <= '0;
      sweep_pend_q <= 1'b0;
    end else begin
      cur_freq_q   <= cur_freq_d;
      tmr_q        <= tmr_d;
      sweep_pend_q <= sweep_pend_d;
    end
  end
`else
  assign sweep_gnt = 1'b0;
`endif

  always_comb begin
    load       = freq_gnt | phase_gnt | sweep_gnt;
    load_sel   = phase_gnt ? SEL_PHASE : SEL_FREQ;
    load_word  = phase_gnt ? phase_aligned : freq_aligned;
    load_width = phase_gnt ? CNT_W'(PHASE_LENGTH) : CNT_W'(ACC_LENGTH);
`ifdef DDS_CFG_SWEEP_EN
    if (sweep_gnt) load_word = WORD_W'(sweep_freq) << (WORD_W - ACC_LENGTH);
`endif
    rdy_d = 1'b1;
    rr_d  = rr_q;
    if (freq_gnt && phase_valid)      rr_d = SEL_PHASE;
    else if (phase_gnt && freq_valid) rr_d = SEL_FREQ;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      rr_q  <= SEL_FREQ;
    end else begin
      rdy_q <= rdy_d;
      rr_q  <= rr_d;
    end
  end

  dds_spi_shifter #(
    .WORD_W  (WORD_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .load       (load),
    .load_sel   (load_sel),
    .load_word  (load_word),
    .load_width (load_width),
    .busy       (busy),
    .spi_clk    (spi_clk),
    .spi_data   (spi_data),
    .freq_cs    (freq_cs),
    .phase_cs   (phaseshift_cs)
  );

endmodule
